// File: rtl/nvram_ctrl_pkg.sv
// Shared types and constants for the NVRAM working/shadow copy controller.
package nvram_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DW     = 8;
  localparam int NV_DEPTH   = 256;
  localparam logic [7:0] NV_FILL = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ST_RD = 3'd1,
    ST_WR = 3'd2,
    RC_RD = 3'd3,
    RC_WR = 3'd4,
    HPS   = 3'd5
  } nv_state_t;

  // Copy states own both RAM ports; the CPU is locked out while one runs.
  function automatic logic is_copy(input nv_state_t s);
    return (s == ST_RD) || (s == ST_WR) || (s == RC_RD) || (s == RC_WR);
  endfunction

endpackage

// File: rtl/nvram_ctrl_req_latch.sv
// Rising-edge detector feeding a sticky pending flag; a fresh edge wins over clear.
module nvram_req_latch (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic clr,
  output logic pend
);

  logic req_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_q <= req;
      // An edge that lands while the copy is starting must re-arm it.
      if (req && !req_q)
        pend <= 1'b1;
      else if (clr)
        pend <= 1'b0;
    end
  end

endmodule

// File: rtl/nvram_ctrl.sv
// STORE/RECALL block copier between working and shadow NVRAM, with HPS ioctl access to shadow.
module nvram_ctrl
  import nvram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DW     = DEF_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce2Hd,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DW-1:0]     cpu_din,
  output logic [DW-1:0]     cpu_dout,
  input  logic              store_req,
  input  logic              recall_req,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DW-1:0]     ioctl_din,
  output logic [DW-1:0]     ioctl_dout,
  output logic [ADDR_W-1:0] wram_addr,
  output logic [DW-1:0]     wram_din,
  output logic              wram_we,
  input  logic [DW-1:0]     wram_dout,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DW-1:0]     sram_din,
  output logic              sram_we,
  input  logic [DW-1:0]     sram_dout,
  output logic              busy,
  output logic              done,
  output logic              dirty
);

  nv_state_t         state;
  logic [ADDR_W-1:0] cnt;
  logic              pend_store, pend_recall;
  logic              clr_store, clr_recall;
  logic              hps_req, upload_q;

  assign hps_req    = ioctl_download | ioctl_upload;
  assign clr_recall = (state == IDLE) && !hps_req && pend_recall;
  assign clr_store  = (state == IDLE) && !hps_req && !pend_recall && pend_store;

  nvram_req_latch u_store_latch (
    .clk   (clk),
    .reset (reset),
    .req   (store_req),
    .clr   (clr_store),
    .pend  (pend_store)
  );

  nvram_req_latch u_recall_latch (
    .clk   (clk),
    .reset (reset),
    .req   (recall_req),
    .clr   (clr_recall),
    .pend  (pend_recall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dirty    <= 1'b0;
      upload_q <= 1'b0;
    end else begin
      done     <= 1'b0;
      upload_q <= ioctl_upload;
      case (state)
        IDLE: begin
          if (hps_req) begin
            state <= HPS;
          end else if (pend_recall) begin
            state <= RC_RD;
            busy  <= 1'b1;
          end else if (pend_store) begin
            state <= ST_RD;
            busy  <= 1'b1;
          end
        end
        ST_RD: state <= ST_WR;
        ST_WR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            dirty <= 1'b1;
          end else begin
            state <= ST_RD;
          end
        end
        RC_RD: state <= RC_WR;
        RC_WR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RC_RD;
          end
        end
        HPS: begin
          // A finished upload means the SD image matches the shadow again.
          if (upload_q && !ioctl_upload)
            dirty <= 1'b0;
          if (ioctl_download && ioctl_wr)
            dirty <= 1'b1;
          if (!hps_req)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port steering; the RAMs register the address, so data returns one cycle later.
  always_comb begin
    wram_addr  = cpu_addr;
    wram_din   = cpu_din;
    wram_we    = cpu_we & ce2Hd;
    sram_addr  = cnt;
    sram_din   = wram_dout;
    sram_we    = 1'b0;
    cpu_dout   = wram_dout;
    ioctl_dout = '0;
    case (state)
      ST_RD, RC_RD: begin
        wram_addr = cnt;
        wram_we   = 1'b0;
      end
      ST_WR: begin
        wram_addr = cnt;
        wram_we   = 1'b0;
        sram_din  = wram_dout;
        sram_we   = 1'b1;
      end
      RC_WR: begin
        wram_addr = cnt;
        wram_din  = sram_dout;
        wram_we   = 1'b1;
      end
      HPS: begin
        sram_addr  = ioctl_addr;
        sram_din   = ioctl_din;
        sram_we    = ioctl_wr & ioctl_download;
        ioctl_dout = sram_dout;
      end
      default: ;
    endcase
    if (is_copy(state))
      cpu_dout = DW'(NV_FILL);
    if (reset) begin
      wram_we    = 1'b0;
      sram_we    = 1'b0;
      cpu_dout   = '0;
      ioctl_dout = '0;
    end
  end

endmodule

// File: tb/tb_nvram_ctrl.sv
// Directed-plus-random bench for nvram_ctrl with behavioural RAMs and an array-level copy model.
module tb_nvram_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce2Hd = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_din = '0, cpu_dout;
  logic       store_req = 1'b0, recall_req = 1'b0;
  logic       ioctl_download = 1'b0, ioctl_upload = 1'b0, ioctl_wr = 1'b0;
  logic [7:0] ioctl_addr = '0, ioctl_din = '0, ioctl_dout;
  logic [7:0] wram_addr, wram_din, wram_dout, sram_addr, sram_din, sram_dout;
  logic       wram_we, sram_we, busy, done, dirty;

  nvram_ctrl dut (
    .clk(clk), .reset(reset), .ce2Hd(ce2Hd), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .store_req(store_req), .recall_req(recall_req),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_dout(ioctl_dout),
    .wram_addr(wram_addr), .wram_din(wram_din), .wram_we(wram_we), .wram_dout(wram_dout),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we), .sram_dout(sram_dout),
    .busy(busy), .done(done), .dirty(dirty)
  );

  always #5 clk = ~clk;

  // Behavioural sync-read RAMs; wimg/simg are bulk-loaded when load is high.
  logic [7:0] wmem [256];
  logic [7:0] smem [256];
  logic [7:0] wimg [256];
  logic [7:0] simg [256];
  logic [7:0] img  [256];
  logic [7:0] exp_m[256];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      wmem <= wimg;
      smem <= simg;
    end else begin
      if (wram_we) wmem[wram_addr] <= wram_din;
      if (sram_we) smem[sram_addr] <= sram_din;
    end
    wram_dout <= wmem[wram_addr];
    sram_dout <= smem[sram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int busy_first, busy_cnt, done_cnt;
  int done_at[$];
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_at.push_back(cyc);
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    busy_first = -1;
    busy_cnt = 0;
    done_cnt = 0;
    done_at.delete();
  endtask

  task automatic preload();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  function automatic int bad_s();
    int n = 0;
    for (int i = 0; i < 256; i++) if (smem[i] !== exp_m[i]) n++;
    return n;
  endfunction

  function automatic int bad_w();
    int n = 0;
    for (int i = 0; i < 256; i++) if (wmem[i] !== exp_m[i]) n++;
    return n;
  endfunction

  int c0, c1;
  logic [7:0] rv, ra;

  initial begin
    // Reset: even with a CPU write presented, nothing may be written.
    ce2Hd = 1'b1; cpu_we = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_ioctl_dout", ioctl_dout, 0);
    chk("rst_wram_we", wram_we, 0);
    chk("rst_sram_we", sram_we, 0);
    ce2Hd = 1'b0; cpu_we = 1'b0;
    @(negedge clk); reset = 1'b0;

    // Store of addr^5A with a CPU write dropped mid-copy.
    for (int i = 0; i < 256; i++) begin
      wimg[i] = 8'(i) ^ 8'h5A;
      simg[i] = 8'($urandom);
    end
    preload();
    clr_mon();
    @(negedge clk); c0 = cyc; store_req = 1'b1;
    @(negedge clk); store_req = 1'b0;
    repeat (199) @(negedge clk);
    cpu_addr = 8'h10; cpu_din = 8'hAB; cpu_we = 1'b1; ce2Hd = 1'b1;
    #1 chk("store_cpu_we_blocked", wram_we, 0);
    @(negedge clk); cpu_we = 1'b0; ce2Hd = 1'b0;
    #1 chk("store_cpu_rd_ff", cpu_dout, 8'hFF);
    while (cyc < c0 + 530) @(negedge clk);
    chk("store_busy_first", busy_first, c0 + 2);
    chk("store_busy_len", busy_cnt, 512);
    chk("store_done_cnt", done_cnt, 1);
    chk("store_done_at", (done_at.size() > 0) ? done_at[0] : -1, c0 + 514);
    exp_m = wimg;
    chk("store_shadow_bad", bad_s(), 0);
    chk("store_dirty", dirty, 1);
    cpu_addr = 8'h10;
    @(negedge clk); #1 chk("store_cpu_10_kept", cpu_dout, 8'h4A);

    // CPU write/read in IDLE.
    rv = 8'($urandom); ra = 8'($urandom_range(32, 255));
    cpu_addr = ra; cpu_din = rv; cpu_we = 1'b1; ce2Hd = 1'b1;
    @(negedge clk); cpu_we = 1'b0; ce2Hd = 1'b0;
    @(negedge clk); #1 chk("idle_cpu_rdback", cpu_dout, rv);

    // Recall of an all-33 shadow into a zeroed working RAM.
    for (int i = 0; i < 256; i++) begin
      wimg[i] = 8'h00;
      simg[i] = 8'h33;
    end
    preload();
    clr_mon();
    @(negedge clk); c0 = cyc; recall_req = 1'b1;
    @(negedge clk); recall_req = 1'b0;
    while (cyc < c0 + 530) @(negedge clk);
    chk("recall_busy_len", busy_cnt, 512);
    chk("recall_done_cnt", done_cnt, 1);
    exp_m = simg;
    chk("recall_work_bad", bad_w(), 0);
    chk("recall_dirty_kept", dirty, 1);

    // Simultaneous edges: recall then store, model applied as two whole-array copies.
    for (int i = 0; i < 256; i++) begin
      wimg[i] = 8'($urandom);
      simg[i] = 8'($urandom);
    end
    preload();
    clr_mon();
    @(negedge clk); c0 = cyc; store_req = 1'b1; recall_req = 1'b1;
    @(negedge clk); store_req = 1'b0; recall_req = 1'b0;
    while (cyc < c0 + 1060) @(negedge clk);
    chk("both_done_cnt", done_cnt, 2);
    chk("both_done0", (done_at.size() > 0) ? done_at[0] : -1, c0 + 514);
    chk("both_done1", (done_at.size() > 1) ? done_at[1] : -1, c0 + 1027);
    chk("both_busy_len", busy_cnt, 1024);
    exp_m = simg;
    chk("both_work_bad", bad_w(), 0);
    chk("both_shadow_bad", bad_s(), 0);

    // Reset in copy cycle 100: bytes 0..49 copied, rest untouched, no done.
    for (int i = 0; i < 256; i++) begin
      wimg[i] = 8'($urandom);
      simg[i] = ~wimg[i];
    end
    preload();
    clr_mon();
    @(negedge clk); c0 = cyc; store_req = 1'b1;
    @(negedge clk); store_req = 1'b0;
    repeat (101) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_busy_len", busy_cnt, 101);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_dirty", dirty, 0);
    for (int i = 0; i < 256; i++) exp_m[i] = (i < 50) ? wimg[i] : simg[i];
    chk("abort_shadow_bad", bad_s(), 0);

    // HPS download with a store edge arriving mid-download.
    clr_mon();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    @(negedge clk); ioctl_download = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      ioctl_addr = 8'(i); ioctl_din = img[i]; ioctl_wr = 1'b1;
      if (i == 100) store_req = 1'b1;
      @(negedge clk); ioctl_wr = 1'b0; store_req = 1'b0;
      @(negedge clk);
    end
    exp_m = img;
    chk("dl_shadow_bad", bad_s(), 0);
    chk("dl_no_busy", busy_cnt, 0);
    chk("dl_dirty", dirty, 1);
    c1 = cyc; ioctl_download = 1'b0;
    while (cyc < c1 + 540) @(negedge clk);
    chk("dl_store_busy_first", busy_first, c1 + 2);
    chk("dl_store_done_cnt", done_cnt, 1);
    exp_m = wimg;
    chk("dl_store_shadow_bad", bad_s(), 0);

    // Upload a few bytes; dropping upload clears dirty.
    ra = 8'($urandom);
    ioctl_addr = ra; ioctl_upload = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("ul_rd0", ioctl_dout, wimg[ra]);
    for (int k = 0; k < 3; k++) begin
      ra = 8'($urandom); ioctl_addr = ra;
      repeat (2) @(negedge clk);
      #1 chk("ul_rd", ioctl_dout, wimg[ra]);
    end
    chk("ul_dirty_before", dirty, 1);
    ioctl_upload = 1'b0;
    @(negedge clk); #1 chk("ul_dirty_cleared", dirty, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
